// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: parses SYNC|ADDR|LEN|DATA[LEN]|CSUM frames from the UART byte stream
// and commits the payload as sequential register writes. Define UART_CMD_TIMEOUT_EN for the inter-byte timeout.
module uart_cmd_ctrl #(
    parameter int unsigned MAX_LEN      = 8,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned TIMEOUT_CLKS = 3480
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    output logic       o_Wr_Valid,
    input  logic       i_Wr_Ready,
    output logic [7:0] o_Wr_Addr,
    output logic [7:0] o_Wr_Data,
    output logic       o_Frame_Done,
    output logic       o_Frame_Err,
    output logic [1:0] o_Err_Code,
    output logic       o_Overrun,
    output logic       o_Busy
);
    // state    | meaning
    // S_SYNC   | idle, hunting for SYNC_BYTE
    // S_ADDR   | expecting base address
    // S_LEN    | expecting payload length
    // S_DATA   | buffering payload bytes
    // S_CSUM   | expecting XOR checksum
    // S_COMMIT | issuing register writes, incoming bytes dropped
    localparam int unsigned IW        = $clog2(MAX_LEN + 1);
    localparam int unsigned AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {S_SYNC, S_ADDR, S_LEN, S_DATA, S_CSUM, S_COMMIT} state_t;

    state_t        state_q;
    logic [7:0]    base_q, csum_q;
    logic [IW-1:0] len_q, idx_q;
    logic [7:0]    pay_q [2**AW];
    logic          wr_valid_q, done_q, err_q, ovr_q;
    logic [7:0]    wr_addr_q, wr_data_q;
    logic [1:0]    err_code_q;
    logic [IW-1:0] idx_d;
    logic          last_idx;

`ifdef UART_CMD_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CLKS + 1);
    logic [TW-1:0] tmr_q;
`else
    // Kept so the parameter list is identical in both builds.
    localparam int unsigned timeout_clks_unused = TIMEOUT_CLKS;
`endif

    assign idx_d    = idx_q + IW'(1);
    assign last_idx = (idx_d == len_q);

    // Payload storage needs no reset; it is always written before it is read.
    always_ff @(posedge i_Clock) begin
        if (state_q == S_DATA && i_Rx_DV)
            pay_q[idx_q[AW-1:0]] <= i_Rx_Byte;
    end

    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            state_q    <= S_SYNC;
            base_q     <= '0;
            csum_q     <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= '0;
            ovr_q      <= 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
            tmr_q      <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            ovr_q  <= 1'b0;
            case (state_q)
                S_SYNC: begin
                    if (i_Rx_DV && i_Rx_Byte == SYNC_BYTE) begin
                        csum_q  <= '0;
                        state_q <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (i_Rx_DV) begin
                        base_q  <= i_Rx_Byte;
                        csum_q  <= csum_q ^ i_Rx_Byte;
                        state_q <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (i_Rx_DV) begin
                        if (i_Rx_Byte == 8'd0 || i_Rx_Byte > MAX_LEN_B) begin
                            err_q      <= 1'b1;
                            err_code_q <= 2'd1;
                            state_q    <= S_SYNC;
                        end else begin
                            len_q   <= i_Rx_Byte[IW-1:0];
                            csum_q  <= csum_q ^ i_Rx_Byte;
                            idx_q   <= '0;
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (i_Rx_DV) begin
                        csum_q <= csum_q ^ i_Rx_Byte;
                        idx_q  <= idx_d;
                        if (last_idx)
                            state_q <= S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (i_Rx_DV) begin
                        if (i_Rx_Byte == csum_q) begin
                            idx_q      <= '0;
                            wr_valid_q <= 1'b1;
                            wr_addr_q  <= base_q;
                            wr_data_q  <= pay_q[0];
                            state_q    <= S_COMMIT;
                        end else begin
                            err_q      <= 1'b1;
                            err_code_q <= 2'd2;
                            state_q    <= S_SYNC;
                        end
                    end
                end
                S_COMMIT: begin
                    ovr_q <= i_Rx_DV;
                    if (wr_valid_q && i_Wr_Ready) begin
                        if (last_idx) begin
                            wr_valid_q <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= S_SYNC;
                        end else begin
                            idx_q     <= idx_d;
                            wr_addr_q <= base_q + 8'(idx_d);
                            wr_data_q <= pay_q[idx_d[AW-1:0]];
                        end
                    end
                end
                default: state_q <= S_SYNC;
            endcase
`ifdef UART_CMD_TIMEOUT_EN
            // Down-counter reloads on every consumed byte; expiry only matters while parsing.
            if (i_Rx_DV) begin
                tmr_q <= TW'(TIMEOUT_CLKS - 1);
            end else if (state_q inside {S_ADDR, S_LEN, S_DATA, S_CSUM}) begin
                if (tmr_q == '0) begin
                    err_q      <= 1'b1;
                    err_code_q <= 2'd3;
                    state_q    <= S_SYNC;
                end else begin
                    tmr_q <= tmr_q - TW'(1);
                end
            end
`endif
        end
    end

    assign o_Wr_Valid   = wr_valid_q;
    assign o_Wr_Addr    = wr_addr_q;
    assign o_Wr_Data    = wr_data_q;
    assign o_Frame_Done = done_q;
    assign o_Frame_Err  = err_q;
    assign o_Err_Code   = err_code_q;
    assign o_Overrun    = ovr_q;
    assign o_Busy       = (state_q != S_SYNC);
endmodule
